// File: rtl/card_rom_arbiter.sv
// card_rom_arbiter: shares the single-port card-sprite ROM between a real-time port 0 and a background port 1
module card_rom_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12,
  parameter int CARD_W     = 32,
  parameter int CARD_H     = 46,
  parameter int NUM_CARDS  = 22,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [4:0]        card0,
  input  logic [4:0]        px0,
  input  logic [5:0]        py0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [4:0]        card1,
  input  logic [4:0]        px1,
  input  logic [5:0]        py1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              range_err
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0]     starve_q, starve_d;
  logic              force1, gnt, oor;
  logic [4:0]        card, px;
  logic [5:0]        py;
  logic [ADDR_W-1:0] addr_d, rom_addr_q;
  logic [2:0]        tag_q [RD_LAT+1];
  logic [2:0]        tail;
  logic [DATA_W-1:0] pix, rdata0_q, rdata1_q;
  logic              rom_en_q, range_err_q, rvalid0_q, rvalid1_q;

  // arbitration: port 0 wins unless port 1 has been denied STARVE_LIM cycles in a row
  always_comb begin
    force1   = req1 && (starve_q == LIM);
    gnt0     = rst && req0 && !force1;
    gnt1     = rst && req1 && (!req0 || force1);
    gnt      = gnt0 || gnt1;
    starve_d = (req1 && !gnt1) ? ((starve_q == LIM) ? starve_q : starve_q + 1'b1) : '0;
  end

  // operand select, linear address (modulo 2^ADDR_W) and range check for the granted port
  always_comb begin
    card   = gnt1 ? card1 : card0;
    px     = gnt1 ? px1 : px0;
    py     = gnt1 ? py1 : py0;
    addr_d = ADDR_W'(card) * ADDR_W'(CARD_W * CARD_H) + ADDR_W'(py) * ADDR_W'(CARD_W) + ADDR_W'(px);
    oor    = int'(card) >= NUM_CARDS || int'(px) >= CARD_W || int'(py) >= CARD_H;
  end

  assign tail = tag_q[RD_LAT];
  assign pix  = tail[0] ? FILL : rom_dout;

  // starvation counter, ROM address stage and {valid, port, fill} tag pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      range_err_q <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      starve_q    <= starve_d;
      rom_en_q    <= gnt && !oor;
      if (gnt) rom_addr_q <= addr_d;
      range_err_q <= range_err_q || (gnt && oor);
      tag_q[0]    <= {gnt, gnt1, oor};
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // response register: routes the returning pixel (or FILL) to the port named in the tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tail[2] && !tail[1];
      rvalid1_q <= tail[2] && tail[1];
      if (tail[2] && !tail[1]) rdata0_q <= pix;
      if (tail[2] && tail[1]) rdata1_q <= pix;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign range_err = range_err_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
endmodule

// File: tb/tb_card_rom_arbiter.sv
// tb_card_rom_arbiter: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances with shared stimulus
module tb_card_rom_arbiter;
  typedef struct {int dut; int due; bit port; logic [11:0] data;} ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [4:0] card0 = '0, px0 = '0, card1 = '0, px1 = '0;
  logic [5:0] py0 = '0, py1 = '0;
  logic [1:0] g0, g1, rv0, rv1, ren, rerr;
  logic [11:0] rd0 [2];
  logic [11:0] rd1 [2];
  logic [11:0] dout [2];
  logic [14:0] ra [2];
  logic [11:0] p2;

  int passed = 0, total = 0, cyc = 0;
  ent_t sb[$];
  ent_t keep[$];
  ent_t e;
  int m_starve = 0;
  logic m_en = 1'b0, m_err = 1'b0;
  logic [14:0] m_addr = '0;
  logic [11:0] m_rd0 [2];
  logic [11:0] m_rd1 [2];
  logic frc, e0, e1, oor, v0, v1;
  logic [4:0] sc, sx;
  logic [5:0] sy;
  logic [14:0] sa;

  always #5 clk = ~clk;

  card_rom_arbiter #(.RD_LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .req0(req0), .card0(card0), .px0(px0), .py0(py0), .gnt0(g0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
    .req1(req1), .card1(card1), .px1(px1), .py1(py1), .gnt1(g1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
    .rom_en(ren[0]), .rom_addr(ra[0]), .rom_dout(dout[0]), .range_err(rerr[0]));

  card_rom_arbiter #(.RD_LAT(2)) u1 (
    .clk(clk), .rst(rst),
    .req0(req0), .card0(card0), .px0(px0), .py0(py0), .gnt0(g0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
    .req1(req1), .card1(card1), .px1(px1), .py1(py1), .gnt1(g1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
    .rom_en(ren[1]), .rom_addr(ra[1]), .rom_dout(dout[1]), .range_err(rerr[1]));

  function automatic logic [11:0] rom_f(input logic [14:0] a);
    return 12'(a * 13 + (a >> 4) + 15'h5a5);
  endfunction

  // reference ROMs with one and two cycles of read latency
  always @(posedge clk) begin
    dout[0] <= rom_f(ra[0]);
    p2      <= rom_f(ra[1]);
    dout[1] <= p2;
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
  endtask

  // cycle model: checks every output of both instances mid-cycle and feeds the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("rst_ctl", d, 32'({g0[d], g1[d], rv0[d], rv1[d], ren[d], rerr[d]}), 32'd0);
        chk("rst_addr", d, 32'(ra[d]), 32'd0);
        chk("rst_rdata", d, 32'({rd0[d], rd1[d]}), 32'd0);
        m_rd0[d] = '0;
        m_rd1[d] = '0;
      end
      sb.delete();
      m_starve = 0;
      m_en = 1'b0;
      m_err = 1'b0;
      m_addr = '0;
    end else begin
      frc = req1 && (m_starve == 8);
      e0 = req0 && !frc;
      e1 = req1 && (!req0 || frc);
      sc = e1 ? card1 : card0;
      sx = e1 ? px1 : px0;
      sy = e1 ? py1 : py0;
      sa = 15'(int'(sc) * 1472 + int'(sy) * 32 + int'(sx));
      oor = (sc > 5'd21) || (sy > 6'd45);
      for (int d = 0; d < 2; d++) begin
        chk("gnt0", d, 32'(g0[d]), 32'(e0));
        chk("gnt1", d, 32'(g1[d]), 32'(e1));
        chk("rom_en", d, 32'(ren[d]), 32'(m_en));
        chk("rom_addr", d, 32'(ra[d]), 32'(m_addr));
        chk("range_err", d, 32'(rerr[d]), 32'(m_err));
        v0 = 1'b0;
        v1 = 1'b0;
        foreach (sb[i]) if (sb[i].dut == d && sb[i].due == cyc) begin
          if (sb[i].port) begin v1 = 1'b1; m_rd1[d] = sb[i].data; end
          else begin v0 = 1'b1; m_rd0[d] = sb[i].data; end
        end
        chk("rvalid0", d, 32'(rv0[d]), 32'(v0));
        chk("rvalid1", d, 32'(rv1[d]), 32'(v1));
        chk("rdata0", d, 32'(rd0[d]), 32'(m_rd0[d]));
        chk("rdata1", d, 32'(rd1[d]), 32'(m_rd1[d]));
      end
      keep.delete();
      foreach (sb[i]) if (sb[i].due > cyc) keep.push_back(sb[i]);
      sb = keep;
      if (e0 || e1) begin
        for (int d = 0; d < 2; d++) begin
          e.dut = d;
          e.due = cyc + 3 + d;
          e.port = e1;
          e.data = oor ? 12'h000 : rom_f(sa);
          sb.push_back(e);
        end
        m_addr = sa;
        m_err = m_err || oor;
      end
      m_en = (e0 || e1) && !oor;
      m_starve = (req1 && !e1) ? ((m_starve < 8) ? m_starve + 1 : 8) : 0;
    end
  end

  task automatic drv(input logic r0, input int c0, input int x0, input int y0,
                     input logic r1, input int c1, input int x1, input int y1);
    req0 = r0; card0 = 5'(c0); px0 = 5'(x0); py0 = 6'(y0);
    req1 = r1; card1 = 5'(c1); px1 = 5'(x1); py1 = 6'(y1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    // single port-0 read: card 5, (3,2) -> address 7427
    drv(1, 5, 3, 2, 0, 0, 0, 0);
    @(negedge clk) chk("t1_gnt0", 0, 32'(g0[0]), 32'd1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_en", 0, 32'(ren[0]), 32'd1);
    chk("t1_addr", 0, 32'(ra[0]), 32'd7427);
    tick();
    tick();
    @(negedge clk);
    chk("t1_rvalid0", 0, 32'(rv0[0]), 32'd1);
    chk("t1_rdata0", 0, 32'(rd0[0]), 32'(rom_f(15'd7427)));
    idle(5);
    // contention: eight port-0 wins, forced port-1 grant, then port 0 again
    for (int i = 0; i < 10; i++) begin
      drv(1, 3, (i <= 8) ? i : 8, 10, i < 9, 7, 4, 5);
      @(negedge clk);
      chk("t2_g0", 0, 32'(g0[0]), 32'(i != 8));
      chk("t2_g1", 0, 32'(g1[0]), 32'(i == 8));
      tick();
    end
    idle(6);
    // out-of-range requests return FILL and set the sticky error flag
    drv(0, 0, 0, 0, 1, 22, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_err", 0, 32'(rerr[0]), 32'd1);
    chk("t3_en", 0, 32'(ren[0]), 32'd0);
    tick();
    drv(1, 2, 0, 46, 0, 0, 0, 0);
    tick();
    drv(1, 31, 31, 45, 0, 0, 0, 0);
    tick();
    drv(1, 4, 1, 1, 0, 0, 0, 0);
    tick();
    idle(6);
    chk("t3_err_sticky", 1, 32'(rerr[1]), 32'd1);
    // alternating back-to-back single-cycle requests with the last valid corners
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drv(1, 21, 31, 45, 0, 0, 0, 0);
      else if (i == 1) drv(0, 0, 0, 0, 1, 0, 0, 0);
      else if (i % 2 == 0) drv(1, $urandom_range(0, 21), $urandom_range(0, 31), $urandom_range(0, 45), 0, 0, 0, 0);
      else drv(0, 0, 0, 0, 1, $urandom_range(0, 21), $urandom_range(0, 31), $urandom_range(0, 45));
      tick();
    end
    idle(6);
    // starvation count clears when port 1 drops its request
    for (int i = 0; i < 5; i++) begin drv(1, 1, i, 3, 1, 9, 9, 9); tick(); end
    drv(1, 1, 5, 3, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1, 6, (i <= 8) ? i : 8, 7, i < 9, 9, 9, 9);
      @(negedge clk);
      chk("t6_g1", 0, 32'(g1[0]), 32'(i == 8));
      tick();
    end
    idle(6);
    // asynchronous reset with three reads in flight
    for (int i = 0; i < 3; i++) begin drv(1, 1, i, 0, 0, 0, 0, 0); tick(); end
    drv(1, 8, 8, 8, 1, 2, 2, 2);
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_ctl", d, 32'({g0[d], g1[d], rv0[d], rv1[d], ren[d], rerr[d]}), 32'd0);
      chk("async_data", d, 32'({rd0[d], rd1[d]}), 32'd0);
    end
    @(posedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    idle(6);
    drv(0, 0, 0, 0, 1, 12, 17, 33);
    tick();
    idle(8);
    chk("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
